// File: rtl/la_frame_deserializer_if.sv
// -----------------------------------------------------------------------------
// la_frame_deserializer_if : serial q/qb pair, word output handshake and status
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface la_frame_deserializer_if #(
    parameter int DATA_W = 8,
    parameter int ERR_W  = 8
);
    logic              q_i;
    logic              qb_i;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              sync_lock;
    logic              pair_err;
    logic [ERR_W-1:0]  err_count;
    logic              overflow;

    modport master (
        output q_i, qb_i, out_ready,
        input  out_data, out_valid, sync_lock, pair_err, err_count, overflow
    );

    modport slave (
        input  q_i, qb_i, out_ready,
        output out_data, out_valid, sync_lock, pair_err, err_count, overflow
    );
endinterface

`default_nettype wire

// File: rtl/la_frame_deserializer.sv
// -----------------------------------------------------------------------------
// la_frame_deserializer : q/qb integrity check, sync hunt, MSB-first word output
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module la_frame_deserializer #(
    parameter int                DATA_W          = 8,
    parameter int                SYNC_W          = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD       = 8'hA5,
    parameter int                FRAMES_PER_SYNC = 4,
    parameter int                ERR_W           = 8
) (
    input  wire logic               wb_clk_i,
    input  wire logic               rst,
    la_frame_deserializer_if.slave  bus
);

    localparam int BCW = $clog2(DATA_W + 1);
    localparam int WCW = $clog2(FRAMES_PER_SYNC + 1);
    localparam logic [BCW-1:0] c_LAST_BIT  = BCW'(DATA_W - 1);
    localparam logic [WCW-1:0] c_LAST_WORD = WCW'(FRAMES_PER_SYNC - 1);

    typedef enum logic [0:0] {
        ST_HUNT  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    // Only the older SYNC_W-1 / DATA_W-1 bits are stored; the current bit completes them.
    logic [SYNC_W-2:0]  r_window;
    logic [DATA_W-2:0]  r_shreg;
    logic [BCW-1:0]     r_bit_cnt;
    logic [WCW-1:0]     r_word_cnt;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_valid;
    logic               r_pair_err;
    logic [ERR_W-1:0]   r_err_count;
    logic               r_overflow;

    logic               w_bit_ok;
    logic [SYNC_W-1:0]  w_win_next;
    logic [DATA_W-1:0]  w_word_next;
    logic               w_word_done;
    logic               w_can_load;

    assign w_bit_ok    = bus.q_i ^ bus.qb_i;
    assign w_win_next  = {r_window, bus.q_i};
    assign w_word_next = {r_shreg, bus.q_i};
    assign w_word_done = (r_state == ST_SHIFT) && w_bit_ok && (r_bit_cnt == c_LAST_BIT);
    assign w_can_load  = !r_out_valid || bus.out_ready;

    always_ff @(posedge wb_clk_i) begin
        if (!rst) begin
            r_state     <= ST_HUNT;
            r_window    <= '0;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_word_cnt  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_pair_err  <= 1'b0;
            r_err_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_pair_err <= !w_bit_ok;
            if (!w_bit_ok && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end

            case (r_state)
                ST_HUNT: begin
                    if (!w_bit_ok) begin
                        r_window <= '0;
                    end else begin
                        r_window <= w_win_next[SYNC_W-2:0];
                        if (w_win_next == SYNC_WORD) begin
                            r_state    <= ST_SHIFT;
                            r_bit_cnt  <= '0;
                            r_word_cnt <= '0;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (!w_bit_ok) begin
                        // Corrupted pair mid-frame: drop the partial word and resynchronise.
                        r_state    <= ST_HUNT;
                        r_window   <= '0;
                        r_bit_cnt  <= '0;
                        r_word_cnt <= '0;
                    end else begin
                        r_shreg <= w_word_next[DATA_W-2:0];
                        if (w_word_done) begin
                            r_bit_cnt <= '0;
                            if (r_word_cnt == c_LAST_WORD) begin
                                r_state    <= ST_HUNT;
                                r_window   <= '0;
                                r_word_cnt <= '0;
                            end else begin
                                r_word_cnt <= r_word_cnt + 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_HUNT;
            endcase

            // A word completing on an accept edge reloads without a bubble.
            if (w_word_done) begin
                if (w_can_load) begin
                    r_out_data  <= w_word_next;
                    r_out_valid <= 1'b1;
                end else begin
                    r_overflow  <= 1'b1;
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.sync_lock = (r_state == ST_SHIFT);
    assign bus.pair_err  = r_pair_err;
    assign bus.err_count = r_err_count;
    assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_la_frame_deserializer.sv
// -----------------------------------------------------------------------------
// tb_la_frame_deserializer : directed table, corner sequences and randomized model check
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_la_frame_deserializer;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    la_frame_deserializer_if #(.DATA_W(8), .ERR_W(8)) bus ();

    la_frame_deserializer #(
        .DATA_W(8), .SYNC_W(8), .SYNC_WORD(8'hA5), .FRAMES_PER_SYNC(4), .ERR_W(8)
    ) dut (
        .wb_clk_i (clk),
        .rst      (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic       q;
        logic       qb;
        logic       rdy;
        logic       exp_lock;
        logic       exp_valid;
        logic       exp_perr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl [17];

    // Reference model state
    logic       m_locked;
    int         m_win, m_acc, m_nbits, m_words;
    logic [7:0] m_data;
    logic       m_valid, m_ovf, m_perr;
    int         m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic q, input logic qb);
        bus.q_i  = q;
        bus.qb_i = qb;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) drive(b[i], ~b[i]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b1);
        rst_n = 1'b1;
    endtask

    task automatic model_step(input logic q, input logic qb, input logic rdy, input logic rn);
        logic accept, new_word;
        logic [7:0] word;
        if (!rn) begin
            m_locked = 0; m_win = 0; m_acc = 0; m_nbits = 0; m_words = 0;
            m_data = 0; m_valid = 0; m_ovf = 0; m_perr = 0; m_err = 0;
            return;
        end
        accept   = m_valid && rdy;
        new_word = 1'b0;
        word     = 8'h00;
        m_perr   = (q == qb);
        if (q == qb) begin
            if (m_err < 255) m_err++;
            m_locked = 0; m_win = 0; m_acc = 0; m_nbits = 0; m_words = 0;
        end else if (!m_locked) begin
            m_win = ((m_win << 1) | int'(q)) & 8'hFF;
            if (m_win == 8'hA5) begin
                m_locked = 1; m_acc = 0; m_nbits = 0; m_words = 0;
            end
        end else begin
            m_acc = ((m_acc << 1) | int'(q)) & 8'hFF;
            m_nbits++;
            if (m_nbits == 8) begin
                new_word = 1'b1;
                word     = m_acc[7:0];
                m_nbits  = 0;
                m_words++;
                if (m_words == 4) begin
                    m_locked = 0; m_win = 0; m_words = 0;
                end
            end
        end
        if (new_word) begin
            if (!m_valid || accept) begin
                m_data  = word;
                m_valid = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (accept) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] pat;
        logic        q, qb, rdy, rn;
        logic [1:0]  bitq[$];
        logic [7:0]  rb;

        rst_n         = 1'b0;
        bus.q_i       = 1'b0;
        bus.qb_i      = 1'b1;
        bus.out_ready = 1'b1;

        // Reset with random pair inputs
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 1'($urandom));
            check("rst_data",  32'(bus.out_data),  32'h0);
            check("rst_valid", 32'(bus.out_valid), 32'h0);
            check("rst_lock",  32'(bus.sync_lock), 32'h0);
            check("rst_perr",  32'(bus.pair_err),  32'h0);
            check("rst_err",   32'(bus.err_count), 32'h0);
            check("rst_ovf",   32'(bus.overflow),  32'h0);
        end
        rst_n = 1'b1;

        // Sync A5 then word 3C, then one extra good bit
        pat = 16'hA53C;
        for (int i = 0; i < 16; i++) begin
            tbl[i].q         = pat[15-i];
            tbl[i].qb        = ~pat[15-i];
            tbl[i].rdy       = 1'b1;
            tbl[i].exp_lock  = (i >= 7);
            tbl[i].exp_valid = (i == 15);
            tbl[i].exp_perr  = 1'b0;
            tbl[i].exp_data  = (i == 15) ? 8'h3C : 8'h00;
        end
        tbl[16] = '{q: 1'b0, qb: 1'b1, rdy: 1'b1, exp_lock: 1'b1, exp_valid: 1'b0,
                    exp_perr: 1'b0, exp_data: 8'h3C};
        for (int i = 0; i < 17; i++) begin
            bus.out_ready = tbl[i].rdy;
            drive(tbl[i].q, tbl[i].qb);
            check("tbl_lock",  32'(bus.sync_lock), 32'(tbl[i].exp_lock));
            check("tbl_valid", 32'(bus.out_valid), 32'(tbl[i].exp_valid));
            check("tbl_perr",  32'(bus.pair_err),  32'(tbl[i].exp_perr));
            check("tbl_data",  32'(bus.out_data),  32'(tbl[i].exp_data));
        end

        // Abort mid-word: three more good bits, then q=qb=1
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        check("abort_pre_lock", 32'(bus.sync_lock), 32'h1);
        drive(1'b1, 1'b1);
        check("abort_perr",  32'(bus.pair_err),  32'h1);
        check("abort_err",   32'(bus.err_count), 32'h1);
        check("abort_lock",  32'(bus.sync_lock), 32'h0);
        check("abort_valid", 32'(bus.out_valid), 32'h0);
        drive(1'b0, 1'b1);
        check("abort_perr_pulse", 32'(bus.pair_err), 32'h0);

        // Overflow with consumer stalled
        bus.out_ready = 1'b0;
        send_byte(8'hA5);
        check("ovf_lock", 32'(bus.sync_lock), 32'h1);
        send_byte(8'h11);
        check("ovf_first_valid", 32'(bus.out_valid), 32'h1);
        check("ovf_first_data",  32'(bus.out_data),  32'h11);
        check("ovf_first_flag",  32'(bus.overflow),  32'h0);
        send_byte(8'h22);
        check("ovf_hold_data",  32'(bus.out_data),  32'h11);
        check("ovf_hold_valid", 32'(bus.out_valid), 32'h1);
        check("ovf_flag",       32'(bus.overflow),  32'h1);
        drive(1'b1, 1'b0);
        check("ovf_stall_data", 32'(bus.out_data), 32'h11);
        bus.out_ready = 1'b1;
        drive(1'b0, 1'b1);
        check("ovf_accept_valid", 32'(bus.out_valid), 32'h0);
        check("ovf_accept_data",  32'(bus.out_data),  32'h11);
        check("ovf_sticky",       32'(bus.overflow),  32'h1);
        do_reset();
        check("ovf_cleared", 32'(bus.overflow), 32'h0);

        // Five words after sync: only four delivered
        send_byte(8'hA5);
        for (int w = 1; w <= 5; w++) begin
            send_byte(8'(w));
            if (w <= 4) begin
                check("frm_valid", 32'(bus.out_valid), 32'h1);
                check("frm_data",  32'(bus.out_data),  32'(w));
                check("frm_lock",  32'(bus.sync_lock), (w < 4) ? 32'h1 : 32'h0);
            end else begin
                check("frm5_valid", 32'(bus.out_valid), 32'h0);
                check("frm5_data",  32'(bus.out_data),  32'h04);
                check("frm5_lock",  32'(bus.sync_lock), 32'h0);
            end
        end
        do_reset();

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b0);
            if (i == 0)   check("sat_first", 32'(bus.err_count), 32'h01);
            if (i == 253) check("sat_fe",    32'(bus.err_count), 32'hFE);
            if (i == 254) check("sat_ff",    32'(bus.err_count), 32'hFF);
        end
        check("sat_end_err",  32'(bus.err_count), 32'hFF);
        check("sat_end_perr", 32'(bus.pair_err),  32'h1);

        // Randomized run against the reference model
        do_reset();
        model_step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 4000; c++) begin
            if (bitq.size() == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: for (int i = 7; i >= 0; i--) bitq.push_back({pat[8+i], ~pat[8+i]});
                    4, 5, 6, 7: begin
                        rb = 8'($urandom);
                        for (int i = 7; i >= 0; i--) bitq.push_back({rb[i], ~rb[i]});
                    end
                    8:       bitq.push_back({2{1'($urandom)}});
                    default: bitq.push_back(2'($urandom));
                endcase
            end
            {q, qb} = bitq.pop_front();
            rdy = ($urandom_range(0, 3) != 0);
            rn  = ($urandom_range(0, 499) != 0);
            bus.out_ready = rdy;
            rst_n         = rn;
            model_step(q, qb, rdy, rn);
            drive(q, qb);
            check("rnd_data",  32'(bus.out_data),  32'(m_data));
            check("rnd_valid", 32'(bus.out_valid), 32'(m_valid));
            check("rnd_lock",  32'(bus.sync_lock), 32'(m_locked));
            check("rnd_perr",  32'(bus.pair_err),  32'(m_perr));
            check("rnd_err",   32'(bus.err_count), 32'(m_err));
            check("rnd_ovf",   32'(bus.overflow),  32'(m_ovf));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
